// File: rtl/parmetry_pkg.sv
// Shared sizing parameters and types for the multiply-add datapath and its
// window accumulator.
package parmetry;

  localparam int unsigned sizeIn  = 8;
  localparam int unsigned sizeOut = 16;

  localparam int unsigned WIN_LEN_DEF = 16;
  localparam int unsigned ACC_W_DEF   = sizeOut + 4;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_t;

endpackage : parmetry

// File: rtl/acc_sat_add.sv
// Saturating unsigned adder: ACC_W-bit accumulator plus B_W-bit sample.
// The sum clamps to all-ones and carry flags the clamp.
module acc_sat_add
  import parmetry::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEF,
  parameter int unsigned B_W   = sizeOut
) (
  input  logic [ACC_W-1:0] a,
  input  logic [B_W-1:0]   b,
  output logic [ACC_W-1:0] sum,
  output logic             carry
);

  logic [ACC_W:0] full;

  always_comb begin
    full  = {1'b0, a} + (ACC_W+1)'(b);
    carry = full[ACC_W];
    sum   = carry ? '1 : full[ACC_W-1:0];
  end

endmodule : acc_sat_add

// File: rtl/mac_window_acc.sv
// Accumulates WIN_LEN accepted samples into a saturating sum and peak,
// then holds {sum, peak, ovf} on a valid/ready port until taken.
module mac_window_acc
  import parmetry::*;
#(
  parameter int unsigned WIN_LEN = WIN_LEN_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [sizeOut-1:0] data_in,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   sum_out,
  output logic [sizeOut-1:0] peak_out,
  output logic               ovf
);

  localparam int unsigned CNT_W = $clog2(WIN_LEN);

  acc_state_t         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [sizeOut-1:0] pk_q, pk_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sat_q, sat_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   sum_q, sum_d;
  logic [sizeOut-1:0] peak_q, peak_d;
  logic               ovf_q, ovf_d;

  logic [ACC_W-1:0]   add_sum;
  logic               add_carry;
  logic [sizeOut-1:0] pk_max;
  logic               accept;
  logic               last_sample;

  acc_sat_add #(
    .ACC_W (ACC_W),
    .B_W   (sizeOut)
  ) u_sat_add (
    .a     (acc_q),
    .b     (data_in),
    .sum   (add_sum),
    .carry (add_carry)
  );

  // Ready is gated by reset so nothing is taken while reset is high.
  assign in_ready    = (state_q == ACCUM) && !reset;
  assign accept      = in_valid && in_ready;
  assign pk_max      = (data_in > pk_q) ? data_in : pk_q;
  assign last_sample = (cnt_q == CNT_W'(WIN_LEN - 1));

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    pk_d        = pk_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    sum_d       = sum_q;
    peak_d      = peak_q;
    ovf_d       = ovf_q;

    // Clear outranks the handshake and any sample; result regs are kept.
    if (clear) begin
      acc_d       = '0;
      pk_d        = '0;
      cnt_d       = '0;
      sat_d       = 1'b0;
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            if (last_sample) begin
              sum_d       = add_sum;
              peak_d      = pk_max;
              ovf_d       = sat_q | add_carry;
              out_valid_d = 1'b1;
              acc_d       = '0;
              pk_d        = '0;
              cnt_d       = '0;
              sat_d       = 1'b0;
              state_d     = HOLD;
            end else begin
              acc_d = add_sum;
              pk_d  = pk_max;
              sat_d = sat_q | add_carry;
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      pk_q        <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      peak_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pk_q        <= pk_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      peak_q      <= peak_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign peak_out  = peak_q;
  assign ovf       = ovf_q;

endmodule : mac_window_acc
